// File: rtl/stall_ctrl_if.sv
// stall_ctrl_if
// Purpose: groups the hazard inputs and stall/divider outputs that connect
// the pipeline stages to the central stall sequencer (stall_ctrl).
// Signals:
//   id_rs, id_rt, id_use_rs, id_use_rt   decode-stage source register usage
//   ex_is_load, ex_rf_we, ex_rf_waddr    execute-stage writeback info
//   ex_div_req                           execute-stage instruction is div/divu
//   mem_req, mem_ack                     data-SRAM access handshake
//   stall[5:0]                           StallBus, one freeze bit per pipe register
//   div_start, div_busy, div_done        divider sequencing
//   stall_cnt[31:0]                      saturating count of PC-stall cycles
// Modports: master = pipeline side, slave = stall_ctrl.
interface stall_ctrl_if;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic        id_use_rs;
  logic        id_use_rt;
  logic        ex_is_load;
  logic        ex_rf_we;
  logic [4:0]  ex_rf_waddr;
  logic        ex_div_req;
  logic        mem_req;
  logic        mem_ack;
  logic [5:0]  stall;
  logic        div_start;
  logic        div_busy;
  logic        div_done;
  logic [31:0] stall_cnt;

  modport master (
    output id_rs, id_rt, id_use_rs, id_use_rt,
    output ex_is_load, ex_rf_we, ex_rf_waddr, ex_div_req,
    output mem_req, mem_ack,
    input  stall, div_start, div_busy, div_done, stall_cnt
  );

  modport slave (
    input  id_rs, id_rt, id_use_rs, id_use_rt,
    input  ex_is_load, ex_rf_we, ex_rf_waddr, ex_div_req,
    input  mem_req, mem_ack,
    output stall, div_start, div_busy, div_done, stall_cnt
  );
endinterface

// File: rtl/stall_ctrl.sv
// stall_ctrl
// Purpose: central hazard/stall sequencer for the 5-stage MIPS pipeline.
// Merges load-use hazards (ID), multi-cycle divide sequencing (EX) and
// data-SRAM wait states (MEM) into one thermometer-coded StallBus, owns the
// divider start/done handshake and counts PC-stall cycles.
// Ports:
//   clk   clock
//   rst   synchronous active-high reset
//   bus   stall_ctrl_if.slave (hazard inputs, stall and divider outputs)
// Parameter:
//   DIV_CYCLES  divider latency in cycles, 2..63
module stall_ctrl #(
  parameter int DIV_CYCLES = 32
) (
  input  logic         clk,
  input  logic         rst,
  stall_ctrl_if.slave  bus
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } div_state_e;

  localparam logic [5:0] DIV_LOAD = 6'(DIV_CYCLES - 1);

  // Each stall source freezes every register upstream of the stage it holds,
  // so the OR of these masks stays thermometer-coded.
  localparam logic [5:0] LU_MASK  = 6'b000011;
  localparam logic [5:0] DIV_MASK = 6'b000111;
  localparam logic [5:0] MEM_MASK = 6'b001111;

  div_state_e  state_q, state_d;
  logic [5:0]  div_cnt_q, div_cnt_d;
  logic [31:0] stall_cnt_q;

  logic        lu;
  logic        mem_wait;
  logic        div_stall;
  logic        div_start;
  logic        div_busy;
  logic        div_done;
  logic [5:0]  stall;

  // Load-use hazard: the instruction in ID reads a register that the load in
  // EX has not produced yet. r0 is hardwired to zero and never hazards.
  assign lu = bus.ex_is_load && bus.ex_rf_we && (bus.ex_rf_waddr != 5'd0) &&
              ((bus.id_use_rs && (bus.id_rs == bus.ex_rf_waddr)) ||
               (bus.id_use_rt && (bus.id_rt == bus.ex_rf_waddr)));

  // An access that completes in the same cycle it is requested costs nothing.
  assign mem_wait = bus.mem_req && !bus.mem_ack;

  // Divider state and down-counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      div_cnt_q <= 6'd0;
    end else begin
      state_q   <= state_d;
      div_cnt_q <= div_cnt_d;
    end
  end

  // Divider next state. The counter keeps running even while memory stalls
  // the pipe; EX simply holds the finished result until it can advance.
  // The done cycle always returns to IDLE so a still-held request cannot
  // retrigger until the following cycle.
  always_comb begin
    state_d   = state_q;
    div_cnt_d = div_cnt_q;
    case (state_q)
      IDLE: begin
        if (bus.ex_div_req) begin
          state_d   = BUSY;
          div_cnt_d = DIV_LOAD;
        end
      end
      BUSY: begin
        if (div_cnt_q == 6'd0) begin
          state_d = IDLE;
        end else begin
          div_cnt_d = div_cnt_q - 6'd1;
        end
      end
      default: begin
        state_d   = IDLE;
        div_cnt_d = 6'd0;
      end
    endcase
  end

  // Divider outputs. The stall is dropped in the done cycle so the divide
  // leaves EX on the next edge.
  always_comb begin
    div_start = 1'b0;
    div_busy  = 1'b0;
    div_done  = 1'b0;
    div_stall = 1'b0;
    case (state_q)
      IDLE: begin
        div_start = bus.ex_div_req;
        div_stall = bus.ex_div_req;
      end
      BUSY: begin
        div_busy  = 1'b1;
        div_done  = (div_cnt_q == 6'd0);
        div_stall = (div_cnt_q != 6'd0);
      end
      default: begin
        div_start = 1'b0;
      end
    endcase
  end

  // StallBus merge: deepest active request wins by construction.
  always_comb begin
    stall = 6'b000000;
    if (lu)        stall = stall | LU_MASK;
    if (div_stall) stall = stall | DIV_MASK;
    if (mem_wait)  stall = stall | MEM_MASK;
  end

  // PC-stall performance counter, saturating at all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= 32'd0;
    end else if (stall[0] && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign bus.stall     = stall;
  assign bus.div_start = div_start;
  assign bus.div_busy  = div_busy;
  assign bus.div_done  = div_done;
  assign bus.stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_stall_ctrl.sv
// tb_stall_ctrl
// Purpose: directed self-checking bench for stall_ctrl with DIV_CYCLES=4.
// Inputs change 1 ns after the rising edge; outputs are compared a further
// 1 ns later, well away from the next edge.
module tb_stall_ctrl;

  logic clk;
  logic rst;
  int   errors;
  int   checks;
  logic [31:0] exp_cnt;

  stall_ctrl_if bus ();

  stall_ctrl #(.DIV_CYCLES(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance to just after the next rising edge.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Drive every hazard input to its inactive value.
  task automatic apply_idle;
    bus.id_rs       = 5'd0;
    bus.id_rt       = 5'd0;
    bus.id_use_rs   = 1'b0;
    bus.id_use_rt   = 1'b0;
    bus.ex_is_load  = 1'b0;
    bus.ex_rf_we    = 1'b0;
    bus.ex_rf_waddr = 5'd0;
    bus.ex_div_req  = 1'b0;
    bus.mem_req     = 1'b0;
    bus.mem_ack     = 1'b0;
  endtask

  // Reset values with idle inputs.
  task automatic test_reset;
    rst = 1'b1;
    apply_idle();
    tick();
    tick();
    #1;
    checks++;
    if (bus.stall !== 6'b000000) begin
      errors++;
      $display("[TB] FAIL reset_stall: got %b expected %b", bus.stall, 6'b000000);
    end
    checks++;
    if ({bus.div_start, bus.div_busy, bus.div_done} !== 3'b000) begin
      errors++;
      $display("[TB] FAIL reset_div: got %b expected %b",
               {bus.div_start, bus.div_busy, bus.div_done}, 3'b000);
    end
    checks++;
    if (bus.stall_cnt !== 32'd0) begin
      errors++;
      $display("[TB] FAIL reset_cnt: got %0h expected %0h", bus.stall_cnt, 32'd0);
    end
    rst = 1'b0;
    exp_cnt = 32'd0;
    tick();
  endtask

  // Load-use detection on rs and rt, plus the r0 exemption.
  task automatic test_load_use;
    bus.ex_is_load  = 1'b1;
    bus.ex_rf_we    = 1'b1;
    bus.ex_rf_waddr = 5'd5;
    bus.id_rs       = 5'd5;
    bus.id_use_rs   = 1'b1;
    #1;
    checks++;
    if (bus.stall !== 6'b000011) begin
      errors++;
      $display("[TB] FAIL lu_rs_stall: got %b expected %b", bus.stall, 6'b000011);
    end
    checks++;
    if (bus.stall_cnt !== 32'd0) begin
      errors++;
      $display("[TB] FAIL lu_cnt_before: got %0d expected %0d", bus.stall_cnt, 0);
    end
    tick();
    exp_cnt = exp_cnt + 32'd1;
    apply_idle();
    #1;
    checks++;
    if (bus.stall !== 6'b000000) begin
      errors++;
      $display("[TB] FAIL lu_clear_stall: got %b expected %b", bus.stall, 6'b000000);
    end
    checks++;
    if (bus.stall_cnt !== 32'd1) begin
      errors++;
      $display("[TB] FAIL lu_cnt_after: got %0d expected %0d", bus.stall_cnt, 1);
    end
    // Destination r0 never hazards.
    bus.ex_is_load  = 1'b1;
    bus.ex_rf_we    = 1'b1;
    bus.ex_rf_waddr = 5'd0;
    bus.id_rs       = 5'd0;
    bus.id_use_rs   = 1'b1;
    #1;
    checks++;
    if (bus.stall !== 6'b000000) begin
      errors++;
      $display("[TB] FAIL lu_r0: got %b expected %b", bus.stall, 6'b000000);
    end
    // rt match with rt in use, then same registers with rt unused.
    bus.ex_rf_waddr = 5'd7;
    bus.id_rs       = 5'd3;
    bus.id_rt       = 5'd7;
    bus.id_use_rt   = 1'b1;
    #1;
    checks++;
    if (bus.stall !== 6'b000011) begin
      errors++;
      $display("[TB] FAIL lu_rt_stall: got %b expected %b", bus.stall, 6'b000011);
    end
    bus.id_use_rt = 1'b0;
    #1;
    checks++;
    if (bus.stall !== 6'b000000) begin
      errors++;
      $display("[TB] FAIL lu_rt_unused: got %b expected %b", bus.stall, 6'b000000);
    end
    // Non-load writer to the same register is not a load-use.
    bus.id_use_rt  = 1'b1;
    bus.ex_is_load = 1'b0;
    #1;
    checks++;
    if (bus.stall !== 6'b000000) begin
      errors++;
      $display("[TB] FAIL lu_not_load: got %b expected %b", bus.stall, 6'b000000);
    end
    apply_idle();
    tick();
  endtask

  // Divide with the request held through the done cycle (cycles 0..4).
  task automatic test_divide;
    logic [5:0] exp_stall;
    bus.ex_div_req = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #1;
      exp_stall = (c < 4) ? 6'b000111 : 6'b000000;
      checks++;
      if (bus.stall !== exp_stall) begin
        errors++;
        $display("[TB] FAIL div_stall c%0d: got %b expected %b", c, bus.stall, exp_stall);
      end
      checks++;
      if ({bus.div_start, bus.div_busy, bus.div_done} !==
          {(c == 0), (c >= 1), (c == 4)}) begin
        errors++;
        $display("[TB] FAIL div_flags c%0d: got %b expected %b", c,
                 {bus.div_start, bus.div_busy, bus.div_done},
                 {(c == 0), (c >= 1), (c == 4)});
      end
      if (c < 4) exp_cnt = exp_cnt + 32'd1;
      tick();
    end
  endtask

  // Request still high in cycle 5 starts a second divide, run it to done.
  task automatic test_back_to_back;
    logic [5:0] exp_stall;
    for (int c = 5; c < 11; c++) begin
      if (c == 6) bus.ex_div_req = 1'b0;
      #1;
      exp_stall = (c >= 5 && c <= 8) ? 6'b000111 : 6'b000000;
      checks++;
      if (bus.stall !== exp_stall) begin
        errors++;
        $display("[TB] FAIL b2b_stall c%0d: got %b expected %b", c, bus.stall, exp_stall);
      end
      checks++;
      if ({bus.div_start, bus.div_busy, bus.div_done} !==
          {(c == 5), (c >= 6 && c <= 9), (c == 9)}) begin
        errors++;
        $display("[TB] FAIL b2b_flags c%0d: got %b expected %b", c,
                 {bus.div_start, bus.div_busy, bus.div_done},
                 {(c == 5), (c >= 6 && c <= 9), (c == 9)});
      end
      if (c >= 5 && c <= 8) exp_cnt = exp_cnt + 32'd1;
      tick();
    end
    #1;
    checks++;
    if (bus.stall_cnt !== exp_cnt) begin
      errors++;
      $display("[TB] FAIL div_cnt: got %0d expected %0d", bus.stall_cnt, exp_cnt);
    end
  endtask

  // SRAM wait for three cycles, then ack; then a zero-wait access.
  task automatic test_mem_wait;
    bus.mem_req = 1'b1;
    bus.mem_ack = 1'b0;
    for (int c = 0; c < 4; c++) begin
      if (c == 3) bus.mem_ack = 1'b1;
      #1;
      checks++;
      if (bus.stall !== ((c < 3) ? 6'b001111 : 6'b000000)) begin
        errors++;
        $display("[TB] FAIL mem_stall c%0d: got %b expected %b", c, bus.stall,
                 (c < 3) ? 6'b001111 : 6'b000000);
      end
      if (c < 3) exp_cnt = exp_cnt + 32'd1;
      tick();
    end
    bus.mem_req = 1'b1;
    bus.mem_ack = 1'b1;
    #1;
    checks++;
    if (bus.stall !== 6'b000000) begin
      errors++;
      $display("[TB] FAIL mem_same_ack: got %b expected %b", bus.stall, 6'b000000);
    end
    apply_idle();
    tick();
    #1;
    checks++;
    if (bus.stall_cnt !== exp_cnt) begin
      errors++;
      $display("[TB] FAIL mem_cnt: got %0d expected %0d", bus.stall_cnt, exp_cnt);
    end
  endtask

  // Memory wait plus load-use during BUSY; divide still finishes on time.
  task automatic test_overlap;
    logic [5:0] exp_stall;
    for (int c = 0; c < 6; c++) begin
      apply_idle();
      if (c == 0) bus.ex_div_req = 1'b1;
      if (c == 1 || c == 2 || c == 4) begin
        bus.mem_req = 1'b1;
        bus.mem_ack = 1'b0;
      end
      if (c == 1 || c == 2) begin
        bus.ex_is_load  = 1'b1;
        bus.ex_rf_we    = 1'b1;
        bus.ex_rf_waddr = 5'd9;
        bus.id_rt       = 5'd9;
        bus.id_use_rt   = 1'b1;
      end
      #1;
      case (c)
        0, 3:    exp_stall = 6'b000111;
        1, 2, 4: exp_stall = 6'b001111;
        default: exp_stall = 6'b000000;
      endcase
      checks++;
      if (bus.stall !== exp_stall) begin
        errors++;
        $display("[TB] FAIL ovl_stall c%0d: got %b expected %b", c, bus.stall, exp_stall);
      end
      checks++;
      if ({bus.div_start, bus.div_busy, bus.div_done} !==
          {(c == 0), (c >= 1 && c <= 4), (c == 4)}) begin
        errors++;
        $display("[TB] FAIL ovl_flags c%0d: got %b expected %b", c,
                 {bus.div_start, bus.div_busy, bus.div_done},
                 {(c == 0), (c >= 1 && c <= 4), (c == 4)});
      end
      if (c <= 4) exp_cnt = exp_cnt + 32'd1;
      tick();
    end
    apply_idle();
    #1;
    checks++;
    if (bus.stall_cnt !== exp_cnt) begin
      errors++;
      $display("[TB] FAIL ovl_cnt: got %0d expected %0d", bus.stall_cnt, exp_cnt);
    end
  endtask

  // Reset in BUSY cycle 2 aborts without a done pulse and clears the count.
  task automatic test_reset_mid_divide;
    bus.ex_div_req = 1'b1;
    tick();
    bus.ex_div_req = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    checks++;
    if ({bus.div_busy, bus.div_done} !== 2'b10) begin
      errors++;
      $display("[TB] FAIL rstdiv_before: got %b expected %b",
               {bus.div_busy, bus.div_done}, 2'b10);
    end
    tick();
    rst = 1'b0;
    exp_cnt = 32'd0;
    for (int c = 0; c < 4; c++) begin
      #1;
      checks++;
      if ({bus.stall, bus.div_busy, bus.div_done} !== 8'b0) begin
        errors++;
        $display("[TB] FAIL rstdiv_after c%0d: got stall=%b busy=%b done=%b expected all 0",
                 c, bus.stall, bus.div_busy, bus.div_done);
      end
      tick();
    end
    #1;
    checks++;
    if (bus.stall_cnt !== 32'd0) begin
      errors++;
      $display("[TB] FAIL rstdiv_cnt: got %0d expected %0d", bus.stall_cnt, 0);
    end
  endtask

  // Preload the counter near all-ones, then keep stalling.
  task automatic test_saturation;
    logic [31:0] exp_sat;
    force dut.stall_cnt_q = 32'hFFFF_FFFD;
    #1;
    release dut.stall_cnt_q;
    exp_sat = 32'hFFFF_FFFD;
    bus.mem_req = 1'b1;
    bus.mem_ack = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (exp_sat != 32'hFFFF_FFFF) exp_sat = exp_sat + 32'd1;
      #1;
      checks++;
      if (bus.stall_cnt !== exp_sat) begin
        errors++;
        $display("[TB] FAIL sat_cnt c%0d: got %0h expected %0h", c, bus.stall_cnt, exp_sat);
      end
    end
    apply_idle();
    tick();
  endtask

  initial begin
    errors  = 0;
    checks  = 0;
    exp_cnt = 32'd0;
    rst     = 1'b1;
    apply_idle();
    test_reset();
    test_load_use();
    test_divide();
    test_back_to_back();
    test_mem_wait();
    test_overlap();
    test_reset_mid_divide();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
